// File: rtl/cpu_mem_pkg.sv
// Shared types and sizing helpers for the fetch/data memory port arbiter.
package cpu_mem_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RESP    = 2'd3
  } arb_state_e;

  // Which CPU port owns the memory for the current transaction
  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

  localparam int unsigned TIMEOUT_DEF    = 16;
  localparam int unsigned STARVE_LIM_DEF = 4;

  // Bits needed to hold values 0..n-1; never less than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Wait counter holds 0..TIMEOUT-1, starve counter holds 0..STARVE_LIM
  localparam int unsigned WAIT_CNT_W   = cnt_w(TIMEOUT_DEF);
  localparam int unsigned STARVE_CNT_W = cnt_w(STARVE_LIM_DEF + 1);

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle timer shared by both grant states. Counts while enabled and
// flags expiry in the cycle its count sits at TIMEOUT-1.
module mem_wait_timer
  import cpu_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CW      = cnt_w(TIMEOUT)
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise advance until the terminal value
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the instruction-fetch port and
// the data port. Data has strict priority unless ARB_STARVE_GUARD_EN is
// defined, in which case fetch is forced through after STARVE_LIM back-to-back
// data grants that it was waiting behind.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
  parameter int unsigned STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic          clk_i,
  input  logic          rst_n,
  // fetch port
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_ready_o,
  // data port
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic [DW-1:0] d_rdata_o,
  output logic          d_ready_o,
  // memory side
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ack_i,
  // status
  output logic          err_o
);

  arb_state_e    state_q;
  grant_e        gnt_q;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          if_ready_q;
  logic          d_ready_q;
  logic          err_q;

  logic          in_grant;
  logic          wait_expire;
  logic          take_d;
  logic          take_i;

  assign in_grant = (state_q == GRANT_I) || (state_q == GRANT_D);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk_i    (clk_i),
    .rst_n    (rst_n),
    .clear_i  (!in_grant),
    .en_i     (in_grant),
    .expire_o (wait_expire)
  );

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned SW = cnt_w(STARVE_LIM + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);

  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;
  logic          force_fetch;

  // Fetch is forced only once it has sat behind LIM data grants and both ports want the memory
  assign force_fetch = d_req_i && if_req_i && (starve_q == LIM);
  assign take_d      = d_req_i && !force_fetch;

  // Starve count: bump on data grants that bypass a waiting fetch, clear on a fetch grant
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (take_d && if_req_i && (starve_q != LIM)) begin
        starve_d = starve_q + 1'b1;
      end else if (take_i) begin
        starve_d = '0;
      end
    end
  end

  // Starve count register
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  // Strict data priority; the starve limit has no effect in this build
  logic unused_starve_lim;
  assign unused_starve_lim = (STARVE_LIM != 0);
  assign take_d = d_req_i;
`endif

  assign take_i = if_req_i && !take_d;

  // Arbiter FSM with registered memory handshake, read data, ready pulses and error flag
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_I;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (take_d) begin
            state_q     <= GRANT_D;
            gnt_q       <= GNT_D;
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we_i;
            mem_addr_q  <= d_addr_i;
            mem_wdata_q <= d_wdata_i;
          end else if (take_i) begin
            state_q     <= GRANT_I;
            gnt_q       <= GNT_I;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr_i;
            mem_wdata_q <= '0;
          end
        end
        GRANT_I, GRANT_D: begin
          // An ack in the expiry cycle still counts as a normal completion
          if (mem_ack_i || wait_expire) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            if (gnt_q == GNT_D) begin
              d_ready_q <= 1'b1;
              if (!mem_we_q) begin
                d_rdata_q <= mem_ack_i ? mem_rdata_i : '0;
              end
            end else begin
              if_ready_q <= 1'b1;
              if_rdata_q <= mem_ack_i ? mem_rdata_i : '0;
            end
            if (!mem_ack_i) begin
              err_q <= 1'b1;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign if_ready_o  = if_ready_q;
  assign d_rdata_o   = d_rdata_q;
  assign d_ready_o   = d_ready_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a memory responder plus a transaction-timeline
// model, checked every cycle, and directed scenarios with literal expectations.
module tb_mem_port_arbiter;

  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int TIMEOUT    = 16;
  localparam int STARVE_LIM = 4;

  logic          clk_i = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req_i = 1'b0;
  logic [AW-1:0] if_addr_i = '0;
  logic [DW-1:0] if_rdata_o;
  logic          if_ready_o;
  logic          d_req_i = 1'b0;
  logic          d_we_i = 1'b0;
  logic [AW-1:0] d_addr_i = '0;
  logic [DW-1:0] d_wdata_i = '0;
  logic [DW-1:0] d_rdata_o;
  logic          d_ready_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          mem_ack_i = 1'b0;
  logic          err_o;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .STARVE_LIM(STARVE_LIM)
  ) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_rdata_o(d_rdata_o), .d_ready_o(d_ready_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .err_o(err_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Backing store used by the responder and by the model's load predictions
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  int ack_delay = 0;   // mem_req cycles before the responder acks
  bit stray_en  = 1'b0; // drive acks while no request is outstanding

  // Model state: one transaction described as a timeline of cycle numbers
  int          t = 0;
  bit          busy = 1'b0;
  int          g_start = 0;
  int          g_len = 0;
  bit          p_port_d, p_we, p_to, take_d;
  logic [31:0] p_addr, p_wdata, p_rdata;
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_d_rdata = '0;
  bit          exp_err = 1'b0;
  int          starve = 0;
  bit          in_g, in_r;
  int          req_cnt = 0;
  int          run_len = 0;
  int          last_run = 0;

  // Compare, advance model, then drive the memory responder (all on the falling edge)
  always @(negedge clk_i) begin
    if (!rst_n) begin
      busy = 1'b0; exp_if_rdata = '0; exp_d_rdata = '0; exp_err = 1'b0; starve = 0;
      chk("rst_mem_req", {31'b0, mem_req_o}, 0);
      chk("rst_mem_we", {31'b0, mem_we_o}, 0);
      chk("rst_mem_addr", mem_addr_o, 0);
      chk("rst_mem_wdata", mem_wdata_o, 0);
      chk("rst_if_ready", {31'b0, if_ready_o}, 0);
      chk("rst_d_ready", {31'b0, d_ready_o}, 0);
      chk("rst_if_rdata", if_rdata_o, 0);
      chk("rst_d_rdata", d_rdata_o, 0);
      chk("rst_err", {31'b0, err_o}, 0);
      mem_ack_i = 1'b0; mem_rdata_i = '0; req_cnt = 0; run_len = 0;
    end else begin
      in_g = busy && (t >= g_start) && (t < g_start + g_len);
      in_r = busy && (t == g_start + g_len);
      if (in_r) begin
        if (p_to) exp_err = 1'b1;
        if (!p_we) begin
          if (p_port_d) exp_d_rdata = p_rdata;
          else          exp_if_rdata = p_rdata;
        end
      end
      chk("mem_req", {31'b0, mem_req_o}, {31'b0, in_g});
      chk("if_ready", {31'b0, if_ready_o}, {31'b0, in_r && !p_port_d});
      chk("d_ready", {31'b0, d_ready_o}, {31'b0, in_r && p_port_d});
      chk("if_rdata", if_rdata_o, exp_if_rdata);
      chk("d_rdata", d_rdata_o, exp_d_rdata);
      chk("err", {31'b0, err_o}, {31'b0, exp_err});
      if (in_g) begin
        chk("mem_addr", mem_addr_o, p_addr);
        chk("mem_we", {31'b0, mem_we_o}, {31'b0, p_we});
        if (p_we) chk("mem_wdata", mem_wdata_o, p_wdata);
      end
      if (mem_req_o) run_len++;
      else if (run_len != 0) begin last_run = run_len; run_len = 0; end

      // Arbitration decision for a free cycle
      if (in_r) begin
        busy = 1'b0;
      end else if (!busy && (d_req_i || if_req_i)) begin
        take_d = d_req_i;
`ifdef ARB_STARVE_GUARD_EN
        if (d_req_i && if_req_i && starve == STARVE_LIM) take_d = 1'b0;
`endif
        if (take_d) begin
          if (if_req_i && starve < STARVE_LIM) starve++;
          p_port_d = 1'b1; p_we = d_we_i; p_addr = d_addr_i; p_wdata = d_wdata_i;
        end else begin
          starve = 0;
          p_port_d = 1'b0; p_we = 1'b0; p_addr = if_addr_i; p_wdata = '0;
        end
        p_to    = (ack_delay >= TIMEOUT);
        g_len   = p_to ? TIMEOUT : ack_delay + 1;
        g_start = t + 1;
        p_rdata = p_to ? 32'h0 : rd(p_addr);
        busy    = 1'b1;
      end

      // Memory responder
      if (mem_req_o) begin
        if (req_cnt == ack_delay) begin
          mem_ack_i = 1'b1;
          if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
          else          mem_rdata_i = rd(mem_addr_o);
        end else begin
          mem_ack_i = 1'b0; mem_rdata_i = 32'h5A5A5A5A;
        end
        req_cnt++;
      end else begin
        req_cnt = 0;
        mem_ack_i = stray_en;
        mem_rdata_i = stray_en ? 32'hBAD0BAD0 : 32'h5A5A5A5A;
      end
    end
    t++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  task automatic wait_ready(input bit port_d, output int cyc);
    cyc = 0;
    while (((port_d ? d_ready_o : if_ready_o) !== 1'b1) && cyc < 200) begin
      step(1);
      cyc++;
    end
    checks++;
    if (cyc >= 200) begin
      errors++;
      $display("FAIL wait_%s: no ready pulse within 200 cycles", port_d ? "d" : "if");
    end
  endtask

  task automatic fetch(input logic [31:0] a, input int dly, output int cyc);
    ack_delay = dly; if_addr_i = a; if_req_i = 1'b1;
    wait_ready(1'b0, cyc);
    $display("fetch addr=0x%08h delay=%0d -> rdata=0x%08h err=%0b after %0d cycles", a, dly, if_rdata_o, err_o, cyc);
    if_req_i = 1'b0;
    step(1);
  endtask

  task automatic data(input bit we, input logic [31:0] a, input logic [31:0] wd, input int dly, output int cyc);
    ack_delay = dly; d_we_i = we; d_addr_i = a; d_wdata_i = wd; d_req_i = 1'b1;
    wait_ready(1'b1, cyc);
    $display("%s addr=0x%08h wdata=0x%08h delay=%0d -> rdata=0x%08h after %0d cycles", we ? "store" : "load", a, wd, dly, d_rdata_o, cyc);
    d_req_i = 1'b0; d_we_i = 1'b0;
    step(1);
  endtask

  int cyc, cyc2, if_cnt, d_cnt;

  initial begin
    mem[32'h40]  = 32'h2010000A;
    mem[32'h44]  = 32'h99999999;
    mem[32'h100] = 32'h11223344;
    step(3);
    rst_n = 1'b1;
    step(2);

    // 1. Fetch only, ack one cycle after mem_req rises
    fetch(32'h40, 1, cyc);
    chk("t1_lat", cyc, 3);
    chk("t1_rdata", if_rdata_o, 32'h2010000A);

    // 2. Simultaneous requests: data first, fetch three cycles after d_ready
    ack_delay = 0; d_we_i = 1'b0; d_addr_i = 32'h100; d_req_i = 1'b1;
    if_addr_i = 32'h40; if_req_i = 1'b1;
    wait_ready(1'b1, cyc);
    chk("t2_d_lat", cyc, 2);
    chk("t2_d_rdata", d_rdata_o, 32'h11223344);
    d_req_i = 1'b0;
    wait_ready(1'b0, cyc2);
    chk("t2_gap", cyc2, 3);
    $display("simultaneous: d_ready after %0d, if_ready %0d cycles later", cyc, cyc2);
    if_req_i = 1'b0;
    step(1);

    // 3. Store with delayed ack, then read it back
    data(1'b1, 32'h8, 32'hDEADBEEF, 3, cyc);
    chk("t3_store_lat", cyc, 5);
    chk("t3_rdata_kept", d_rdata_o, 32'h11223344);
    data(1'b0, 32'h8, 32'h0, 0, cyc);
    chk("t3_readback", d_rdata_o, 32'hDEADBEEF);

    // Ack in the very cycle the timer expires: normal completion
    fetch(32'h40, TIMEOUT - 1, cyc);
    step(1);
    chk("late_ack_run", last_run, TIMEOUT);
    chk("late_ack_err", {31'b0, err_o}, 0);

    // Stray acks around a transaction are ignored
    stray_en = 1'b1;
    step(3);
    data(1'b0, 32'h100, 32'h0, 2, cyc);
    step(2);
    stray_en = 1'b0;
    chk("stray_rdata", d_rdata_o, 32'h11223344);

    // 4. Timeout: no ack at all
    fetch(32'h44, 1000, cyc);
    step(1);
    chk("t4_run", last_run, TIMEOUT);
    chk("t4_rdata", if_rdata_o, 32'h0);
    chk("t4_err", {31'b0, err_o}, 1);
    fetch(32'h40, 0, cyc);
    chk("t4_err_sticky", {31'b0, err_o}, 1);

    // 5. Reset while the data grant is waiting
    ack_delay = 1000; d_we_i = 1'b0; d_addr_i = 32'h100; d_req_i = 1'b1;
    step(4);
    rst_n = 1'b0;
    d_req_i = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    data(1'b0, 32'h100, 32'h0, 0, cyc);
    chk("t5_after_rst", d_rdata_o, 32'h11223344);
    chk("t5_err_cleared", {31'b0, err_o}, 0);

    // 6. Both requests held continuously
    ack_delay = 0; d_we_i = 1'b0; d_addr_i = 32'h100; d_req_i = 1'b1;
    if_addr_i = 32'h40; if_req_i = 1'b1;
    if_cnt = 0; d_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (if_ready_o) if_cnt++;
      if (d_ready_o) d_cnt++;
    end
    $display("held requests over 60 cycles: %0d data grants, %0d fetch grants", d_cnt, if_cnt);
`ifdef ARB_STARVE_GUARD_EN
    chk("t6_fetch_share", {31'b0, (if_cnt > 0) && (d_cnt >= 4 * if_cnt) && (d_cnt <= 4 * if_cnt + 4)}, 1);
`else
    chk("t6_no_fetch", if_cnt, 0);
    chk("t6_data_only", {31'b0, d_cnt >= 15}, 1);
`endif
    d_req_i = 1'b0;
    wait_ready(1'b0, cyc);
    if_req_i = 1'b0;
    step(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
